// File: rtl/register_bank.sv
// register_bank: RC-addressed 256-byte buffer plus BASE/LEN/CTRL registers driving one burst per start
module register_bank #(
    parameter int DATA_W  = 8,
    parameter int ADDR_W  = 9,
    parameter int MAX_LEN = 32,
    localparam int LEN_W  = $clog2(MAX_LEN + 1),
    localparam int DEPTH  = 256,
    localparam int IDX_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] rc_rb_addr,
    input  logic [DATA_W-1:0] rc_rb_data,
    input  logic              rc_rb_req,
    input  logic              rc_rb_rw,
    input  logic              rc_rb_idle,
    output logic              rb_rc_ack,
    output logic [DATA_W-1:0] rb_rc_data,
    output logic              rb_rc_rd_done,
    output logic              rb_bst_req,
    input  logic              bst_rb_gnt,
    output logic [IDX_W-1:0]  rb_bst_addr,
    output logic [LEN_W-1:0]  rb_bst_len,
    output logic              rb_bst_wr,
    output logic [DATA_W-1:0] rb_bst_wdata,
    output logic              rb_bst_wvalid,
    input  logic              bst_rb_wready,
    input  logic [DATA_W-1:0] bst_rb_rdata,
    input  logic              bst_rb_rvalid,
    output logic              rb_bst_busy
);
    typedef enum logic [1:0] {S_IDLE, S_REQ, S_XFER, S_DONE} state_t;

    state_t            state_q, state_d;
    logic              req_q, req_d, ack_q, ack_d, rd_done_q, rd_done_d, dir_q, dir_d;
    logic [IDX_W-1:0]  base_q, base_d;
    logic [LEN_W-1:0]  len_q, len_d, beat_q, beat_d;
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic              strobe, wr_acc, start, busy, beat_step, last_beat, mem_we;
    logic [IDX_W-1:0]  burst_idx, mem_waddr;
    logic [DATA_W-1:0] mem_wdata;
    logic              unused_idle;

    assign unused_idle = rc_rb_idle;

    // RC access decode: one strobe per request, register writes only while idle
    always_comb begin
        strobe    = rc_rb_req & ~req_q;
        wr_acc    = strobe & rc_rb_rw & ~busy;
        start     = wr_acc & (rc_rb_addr == ADDR_W'(DEPTH + 2));
        burst_idx = base_q + IDX_W'(beat_q);
    end

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // FSM next state: zero-length start skips straight to DONE
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  state_d = start ? ((len_q != '0) ? S_REQ : S_DONE) : S_IDLE;
            S_REQ:   state_d = bst_rb_gnt ? S_XFER : S_REQ;
            S_XFER:  state_d = (beat_step & last_beat) ? S_DONE : S_XFER;
            default: state_d = S_IDLE;
        endcase
    end

    // FSM outputs and beat handshake
    always_comb begin
        busy          = state_q != S_IDLE;
        rb_bst_busy   = busy;
        rb_bst_req    = state_q == S_REQ;
        rb_bst_wvalid = (state_q == S_XFER) & dir_q;
        rb_bst_wdata  = rb_bst_wvalid ? mem_q[burst_idx] : '0;
        beat_step     = (state_q == S_XFER) & (dir_q ? bst_rb_wready : bst_rb_rvalid);
        last_beat     = (beat_q + LEN_W'(1)) == len_q;
        rb_bst_addr   = base_q;
        rb_bst_len    = len_q;
        rb_bst_wr     = dir_q;
        rb_rc_ack     = ack_q;
        rb_rc_rd_done = rd_done_q;
    end

    // next values of the control registers, beat counter and pulses
    always_comb begin
        req_d     = rc_rb_req;
        ack_d     = strobe;
        base_d    = (wr_acc && rc_rb_addr == ADDR_W'(DEPTH)) ? IDX_W'(rc_rb_data) : base_q;
        len_d     = (wr_acc && rc_rb_addr == ADDR_W'(DEPTH + 1))
                    ? ((rc_rb_data > DATA_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : LEN_W'(rc_rb_data))
                    : len_q;
        dir_d     = start ? rc_rb_data[0] : dir_q;
        beat_d    = (state_q == S_DONE) ? '0 : beat_step ? beat_q + LEN_W'(1) : beat_q;
        rd_done_d = (state_q == S_DONE) & ~dir_q;
    end

    // control registers and pulse flops
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_q     <= 1'b0;
            ack_q     <= 1'b0;
            rd_done_q <= 1'b0;
            dir_q     <= 1'b0;
            base_q    <= '0;
            len_q     <= '0;
            beat_q    <= '0;
        end else begin
            req_q     <= req_d;
            ack_q     <= ack_d;
            rd_done_q <= rd_done_d;
            dir_q     <= dir_d;
            base_q    <= base_d;
            len_q     <= len_d;
            beat_q    <= beat_d;
        end
    end

    // single buffer write port: RC writes only when idle, burst read beats only when busy
    always_comb begin
        mem_we    = (wr_acc & (rc_rb_addr < ADDR_W'(DEPTH))) | (beat_step & ~dir_q);
        mem_waddr = busy ? burst_idx : rc_rb_addr[IDX_W-1:0];
        mem_wdata = busy ? bst_rb_rdata : rc_rb_data;
    end

    // buffer storage, deliberately not reset
    always_ff @(posedge clk) begin
        if (mem_we) mem_q[mem_waddr] <= mem_wdata;
    end

    // RC read mux, driven only while a request is present
    always_comb begin
        rb_rc_data = !rc_rb_req                          ? '0 :
                     (rc_rb_addr < ADDR_W'(DEPTH))       ? mem_q[rc_rb_addr[IDX_W-1:0]] :
                     (rc_rb_addr == ADDR_W'(DEPTH))      ? DATA_W'(base_q) :
                     (rc_rb_addr == ADDR_W'(DEPTH + 1))  ? DATA_W'(len_q) :
                     (rc_rb_addr == ADDR_W'(DEPTH + 2))  ? DATA_W'({busy, dir_q}) : '0;
    end
endmodule
